// File: rtl/board_store.sv
// Game-board cell store: validates and atomically commits one- or two-stone placements.
// Optional per-player stone counters are built only when BOARD_STONE_COUNT_EN is defined.
module board_store #(
  parameter int BOARD_SIZE = 19,
  parameter int COORD_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_pair,
  input  logic               req_player,
  input  logic [COORD_W-1:0] xa,
  input  logic [COORD_W-1:0] ya,
  input  logic [COORD_W-1:0] xb,
  input  logic [COORD_W-1:0] yb,
  output logic               done,
  output logic [1:0]         err,
  input  logic               clear_req,
  output logic               busy,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic [1:0]         rd_data,
  output logic [9:0]         stones_p0,
  output logic [9:0]         stones_p1
);

  localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [COORD_W-1:0] EDGE = COORD_W'(BOARD_SIZE);
  localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_OCC   = 2'b10;
  localparam logic [1:0] E_SAME  = 2'b11;

  typedef enum logic [2:0] {CLEAR, IDLE, CHK_A, CHK_B, COMMIT} state_t;

  state_t state, state_next;

  logic [1:0]         board [CELLS];
  logic [IDX_W-1:0]   sweep;
  logic               pair_q, player_q;
  logic [COORD_W-1:0] xa_q, ya_q, xb_q, yb_q;
  logic               done_next;
  logic [1:0]         err_next;
  logic               accept;
  logic               a_oor, b_oor, same_ab, a_occ, b_occ;
  logic [IDX_W-1:0]   idx_a, idx_b, idx_rd;
  logic [1:0]         wr_val;
  logic               rd_in;
  logic [1:0]         rd_next;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return IDX_W'(y) * IDX_W'(BOARD_SIZE) + IDX_W'(x);
  endfunction

  assign req_ready = (state == IDLE) && !clear_req;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  assign idx_a   = cell_idx(xa_q, ya_q);
  assign idx_b   = cell_idx(xb_q, yb_q);
  assign a_oor   = (xa_q >= EDGE) || (ya_q >= EDGE);
  assign b_oor   = (xb_q >= EDGE) || (yb_q >= EDGE);
  assign same_ab = (xa_q == xb_q) && (ya_q == yb_q);
  assign a_occ   = board[idx_a][1];
  assign b_occ   = board[idx_b][1];
  assign wr_val  = {1'b1, player_q};

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = E_OK;
    case (state)
      CLEAR:  if (sweep == LAST_CELL) state_next = IDLE;
      IDLE: begin
        if (clear_req)      state_next = CLEAR;
        else if (req_valid) state_next = CHK_A;
      end
      CHK_A: begin
        if (a_oor) begin
          state_next = IDLE; done_next = 1'b1; err_next = E_RANGE;
        end else if (a_occ) begin
          state_next = IDLE; done_next = 1'b1; err_next = E_OCC;
        end else if (pair_q) begin
          state_next = CHK_B;
        end else begin
          state_next = COMMIT; done_next = 1'b1;
        end
      end
      CHK_B: begin
        if (b_oor) begin
          state_next = IDLE; done_next = 1'b1; err_next = E_RANGE;
        end else if (same_ab) begin
          state_next = IDLE; done_next = 1'b1; err_next = E_SAME;
        end else if (b_occ) begin
          state_next = IDLE; done_next = 1'b1; err_next = E_OCC;
        end else begin
          state_next = COMMIT; done_next = 1'b1;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // done is registered on the edge that leaves a check state, so the ok pulse overlaps COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      sweep <= '0;
      done  <= 1'b0;
      err   <= E_OK;
    end else begin
      state <= state_next;
      sweep <= (state == CLEAR) ? sweep + 1'b1 : '0;
      done  <= done_next;
      err   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pair_q   <= req_pair;
      player_q <= req_player;
      xa_q     <= xa;
      ya_q     <= ya;
      xb_q     <= xb;
      yb_q     <= yb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        board[sweep] <= 2'b00;
      end else if (state == COMMIT) begin
        board[idx_a] <= wr_val;
        if (pair_q) board[idx_b] <= wr_val;
      end
    end
  end

  // Read forwarding so a write landing on the sampling edge is already visible.
  assign rd_in  = (rd_x < EDGE) && (rd_y < EDGE);
  assign idx_rd = cell_idx(rd_x, rd_y);

  always_comb begin
    rd_next = 2'b00;
    if (rd_in) begin
      rd_next = board[idx_rd];
      if (state == CLEAR && sweep == idx_rd) rd_next = 2'b00;
      if (state == COMMIT && idx_a == idx_rd) rd_next = wr_val;
      if (state == COMMIT && pair_q && idx_b == idx_rd) rd_next = wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 2'b00;
    else     rd_data <= rd_next;
  end

`ifdef BOARD_STONE_COUNT_EN
  logic [9:0] add_n;
  assign add_n = 10'd1 + 10'(pair_q);

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && clear_req)) begin
      stones_p0 <= '0;
      stones_p1 <= '0;
    end else if (state == COMMIT) begin
      if (player_q) stones_p1 <= stones_p1 + add_n;
      else          stones_p0 <= stones_p0 + add_n;
    end
  end
`else
  assign stones_p0 = '0;
  assign stones_p1 = '0;
`endif

endmodule
